// File: rtl/seg14_pkg.sv
// Character codes and the 14-segment font table shared by the display mux.
// Bit 13 = segment a, then b,c,d,e,f,g1,g2,h,i,j,k,l,m down to bit 0.
package seg14_pkg;

  localparam logic [5:0] CH_A = 6'd0,  CH_B = 6'd1,  CH_C = 6'd2,  CH_D = 6'd3,
                         CH_E = 6'd4,  CH_F = 6'd5,  CH_G = 6'd6,  CH_H = 6'd7,
                         CH_I = 6'd8,  CH_J = 6'd9,  CH_K = 6'd10, CH_L = 6'd11,
                         CH_M = 6'd12, CH_N = 6'd13, CH_O = 6'd14, CH_P = 6'd15,
                         CH_Q = 6'd16, CH_R = 6'd17, CH_S = 6'd18, CH_T = 6'd19,
                         CH_U = 6'd20, CH_V = 6'd21, CH_W = 6'd22, CH_X = 6'd23,
                         CH_Y = 6'd24, CH_Z = 6'd25;
  localparam logic [5:0] CH_0 = 6'd26, CH_1 = 6'd27, CH_2 = 6'd28, CH_3 = 6'd29,
                         CH_4 = 6'd30, CH_5 = 6'd31, CH_6 = 6'd32, CH_7 = 6'd33,
                         CH_8 = 6'd34, CH_9 = 6'd35;
  localparam logic [5:0] CH_SPACE = 6'd36, CH_NTILDE = 6'd37;

  // Codes without an entry (space and 38..63) fall to the dark default.
  localparam logic [13:0] FONT_TAB [64] = '{
    CH_A: 14'b11101111000000, CH_B: 14'b11110001010010, CH_C: 14'b10011100000000,
    CH_D: 14'b11110000010010, CH_E: 14'b10011110000000, CH_F: 14'b10001110000000,
    CH_G: 14'b10111101000000, CH_H: 14'b01101111000000, CH_I: 14'b10010000010010,
    CH_J: 14'b01111000000000, CH_K: 14'b00001110001100, CH_L: 14'b00011100000000,
    CH_M: 14'b01101100101000, CH_N: 14'b01101100100100, CH_O: 14'b11111100000000,
    CH_P: 14'b11001111000000, CH_Q: 14'b11111100000100, CH_R: 14'b11001111000100,
    CH_S: 14'b10110111000000, CH_T: 14'b10000000010010, CH_U: 14'b01111100000000,
    CH_V: 14'b00001100001001, CH_W: 14'b01101100000101, CH_X: 14'b00000000101101,
    CH_Y: 14'b00000000101010, CH_Z: 14'b10010000001001,
    CH_0: 14'b11111100001001, CH_1: 14'b01100000001000, CH_2: 14'b11011011000000,
    CH_3: 14'b11110001000000, CH_4: 14'b01100111000000, CH_5: 14'b10110111000000,
    CH_6: 14'b10111111000000, CH_7: 14'b11100000000000, CH_8: 14'b11111111000000,
    CH_9: 14'b11110111000000, CH_NTILDE: 14'b10101011000000,
    default: 14'b0
  };

endpackage

// File: rtl/seg14_font.sv
// Combinational character-code to 14-segment pattern decode.
module seg14_font
  import seg14_pkg::*;
(
  input  logic [5:0]  code,
  output logic [13:0] pattern
);

  assign pattern = FONT_TAB[code];

endmodule

// File: rtl/seg14_scroll_mux.sv
// Multiplexed 14-segment scroller: message buffer, digit scan, frame-aligned scroll.
// Pins lag the digit index by one cycle; length/offset only change at frame boundaries.
module seg14_scroll_mux
  import seg14_pkg::*;
#(
  parameter int N_DIGITS   = 12,
  parameter int MSG_LEN    = 32,
  parameter int PRESCALE   = 1,
  parameter int SCROLL_DIV = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [$clog2(MSG_LEN)-1:0]   wr_addr,
  input  logic [5:0]                   wr_data,
  input  logic [$clog2(MSG_LEN):0]     cfg_len,
  input  logic                         scroll_en,
  input  logic                         blank,
  output logic [N_DIGITS-1:0]          sel,
  output logic [13:0]                  segm,
  output logic                         frame_done
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(N_DIGITS);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  logic [5:0]    msg_mem [MSG_LEN];
  logic [PW-1:0] pcnt;
  logic [DW-1:0] d;
  logic [AW-1:0] ptr, offset, off_inc, off_next, ptr_inc;
  logic [FW-1:0] fcnt;
  logic [LW-1:0] len_r;
  logic          tick, wrap, show_space;
  logic [5:0]    code;
  logic [13:0]   glyph;
  logic [N_DIGITS-1:0] sel_oh;

  assign tick = (pcnt == PW'(PRESCALE - 1));
  assign wrap = tick && (d == DW'(N_DIGITS - 1));

  // ptr tracks (offset + d) mod len incrementally, so no divider is needed.
  always_comb begin
    off_inc = offset;
    if (fcnt == FW'(SCROLL_DIV - 1) && len_r != '0)
      off_inc = (({1'b0, offset} + LW'(1)) == len_r) ? '0 : offset + AW'(1);
    off_next = scroll_en ? off_inc : '0;
    if (cfg_len <= {1'b0, off_next})
      off_next = '0;
    ptr_inc = (({1'b0, ptr} + LW'(1)) >= len_r) ? '0 : ptr + AW'(1);
  end

  always_comb begin
    show_space = (len_r == '0) || (!scroll_en && (LW'(d) >= len_r));
    code       = show_space ? CH_SPACE : msg_mem[ptr];
    sel_oh     = '0;
    sel_oh[d]  = 1'b1;
  end

  seg14_font u_font (
    .code    (code),
    .pattern (glyph)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt       <= '0;
      d          <= '0;
      ptr        <= '0;
      offset     <= '0;
      fcnt       <= '0;
      len_r      <= cfg_len;
      sel        <= '0;
      segm       <= '0;
      frame_done <= 1'b0;
      for (int i = 0; i < MSG_LEN; i++)
        msg_mem[i] <= CH_SPACE;
    end else begin
      if (wr_en)
        msg_mem[wr_addr] <= wr_data;
      pcnt       <= tick ? '0 : pcnt + PW'(1);
      frame_done <= wrap;
      if (tick) begin
        if (wrap) begin
          d      <= '0;
          ptr    <= off_next;
          offset <= off_next;
          len_r  <= cfg_len;
          if (!scroll_en || fcnt == FW'(SCROLL_DIV - 1))
            fcnt <= '0;
          else
            fcnt <= fcnt + FW'(1);
        end else begin
          d   <= d + DW'(1);
          ptr <= ptr_inc;
        end
      end
      sel  <= blank ? '0 : sel_oh;
      segm <= blank ? '0 : glyph;
    end
  end

endmodule

// File: doc/seg14_scroll_mux.md
SEG14_SCROLL_MUX -- requirements
Module: seg14_scroll_mux

Interface
REQ-001 SHALL have parameter N_DIGITS, default 12: number of multiplexed 14-segment digits, 2..16.
REQ-002 SHALL have parameter MSG_LEN, default 32: message buffer depth in characters, power of two, at least N_DIGITS.
REQ-003 SHALL have parameter PRESCALE, default 1: clk cycles per digit slot, at least 1.
REQ-004 SHALL have parameter SCROLL_DIV, default 64: frames per scroll step, at least 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge clk.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port wr_en, input, 1 bit: message buffer write strobe.
REQ-008 SHALL have port wr_addr, input, clog2(MSG_LEN) bits: buffer write index.
REQ-009 SHALL have port wr_data, input, 6 bits: character code to write.
REQ-010 SHALL have port cfg_len, input, clog2(MSG_LEN)+1 bits: active message length, 0..MSG_LEN.
REQ-011 SHALL have port scroll_en, input, 1 bit: 1 = rotate the message, 0 = static.
REQ-012 SHALL have port blank, input, 1 bit: forces the display dark.
REQ-013 SHALL have port sel, output, N_DIGITS bits: registered one-hot digit select.
REQ-014 SHALL have port segm, output, 14 bits: registered segment pattern, bit 13 = segment a.
REQ-015 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each full digit scan.

Function
REQ-016 SHALL decode character codes as follows:
- 0-25 map to A-Z; 26-35 map to 0-9; 36 maps to space (all zeros); 37 maps to N-tilde (10101011000000).
- Codes 38-63 map to space.
REQ-017 SHALL use these fixed patterns:
- A = 11101111000000, I = 10010000010010, T = 10000000010010.
- 0 = 11111100001001, 2 = 11011011000000, 3 = 11110001000000.
REQ-018 SHALL run a prescaler counting 0..PRESCALE-1 and assert an internal tick when the count equals PRESCALE-1; with PRESCALE=1 the tick is asserted every cycle.
REQ-019 SHALL advance digit index d on each tick: 0..N_DIGITS-1, then wrap to 0.
REQ-020 SHALL pulse frame_done for exactly one cycle on the tick where d wraps from N_DIGITS-1 to 0.
REQ-021 SHALL, one cycle after d takes a value, set sel to one-hot(d) and segm to font(buffer[(offset+d) mod len]); latency from index to pins is 1 cycle.
REQ-022 SHALL output space for digit d when scroll_en=0 and d >= len.
REQ-023 SHALL output space for every digit when len = 0, regardless of scroll_en.
REQ-024 SHALL sample cfg_len into the internal len register only at frame boundaries (the frame_done tick) and at reset release; a mid-frame change SHALL never tear a frame.
REQ-025 SHALL, with scroll_en=1 and len>0, increment offset mod len once every SCROLL_DIV frames, applied at a frame boundary.
REQ-026 SHALL clear offset to 0 at the next frame boundary after scroll_en=0 is seen.
REQ-027 SHALL clear offset to 0 when the newly sampled len is at most offset.
REQ-028 SHALL commit a write (wr_en=1) at the clock edge; a read of the same address in that cycle SHALL return the old data.
REQ-029 SHALL apply the last write when two writes hit the same address on consecutive cycles.
REQ-030 SHALL, while blank=1, drive sel=0 and segm=0 with all counters, scrolling and writes still running; release SHALL resume on the next registered update with no glitch.

Reset
REQ-031 SHALL, on rst=1 at a clk edge, set the following on the next cycle:
- sel=0, segm=0, frame_done=0, prescaler=0, d=0, offset=0, frame counter=0, len=cfg_len.
REQ-032 SHALL fill every buffer entry with code 36 (space) during reset; a write with rst=1 SHALL be ignored.
REQ-033 SHALL abandon a reset asserted mid-frame immediately; the first digit output after release SHALL be digit 0.

Structure
REQ-034 SHALL place the character code localparams (CH_A..CH_Z, CH_0..CH_9, CH_SPACE=36, CH_NTILDE=37) and the 64-entry 14-bit font table in package seg14_pkg.
REQ-035 SHALL implement the font decode as combinational sub-module seg14_font (6-bit code in, 14-bit pattern out).
REQ-036 SHALL keep the timing chain and buffer in seg14_scroll_mux; the target size is 150-300 RTL lines.

Verification
REQ-037 SHALL verify the static message: defaults, PRESCALE=1, write "ITA 2023" (8,19,0,36,28,26,28,29), cfg_len=8, scroll_en=0 -> sel walks 0x001..0x800, segm = I,T,A,space,2,0,2,3, then space x4; frame_done every 12 cycles.
REQ-038 SHALL verify scrolling: same message, scroll_en=1, SCROLL_DIV=1 -> frame k shows digit0 = char[k mod 8]; offset wraps 7 -> 0.
REQ-039 SHALL verify the prescaler: PRESCALE=4 -> sel holds each one-hot value 4 cycles; frame_done period is 48 cycles.
REQ-040 SHALL verify mid-frame length change: cfg_len 8 -> 3 at digit 5 -> current frame unchanged; next frame shows I,T,A then space.
REQ-041 SHALL verify blank and reset: blank=1 for 30 cycles -> sel=0, segm=0 while frame_done keeps pulsing; rst pulse mid-frame -> sel=0 next cycle, all digits space afterwards.
REQ-042 SHALL verify out-of-range codes and write collision: write code 50 -> space; write the displayed address on the display cycle -> old glyph now, new glyph next frame.
